hazard_ctrl: RTL and testbench

- Hazard scheduler for the 5-stage MIPS pipeline. It sits beside the decode stage.
- Keeps a shadow scoreboard of in-flight destination registers and their remaining Tnew for the E, M and W stages. Compares it each cycle against the Tuse and source registers of the instruction in D.
- Produces the D-stage stall, the slot-clear for E, and the ForwardRs/ForwardRt selects that steer the EMF bypass bus into D.
- Also sequences the multi-cycle mult/div unit: a busy counter that stalls HI/LO users until the unit finishes.

---
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 5-stage MIPS pipeline: scoreboard-based stall/forward control plus mult/div busy sequencing.
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_D,
    input  logic [5:0]  Tuse_D,
    input  logic [2:0]  Tnew_D,
    input  logic [4:0]  WR_D,
    input  logic        RFWr_D,
    input  logic        MDStart_D,
    input  logic        MDIsDiv_D,
    input  logic        MDUse_D,
    output logic        Stall_O,
    output logic        ClrE_O,
    output logic        ForwardRs_D_O,
    output logic        ForwardRt_D_O,
    output logic        MDBusy_O,
    output logic [31:0] StallCnt_O
);

    function automatic logic [2:0] dec_sat0(input logic [2:0] t);
        return (t == 3'd0) ? 3'd0 : t - 3'd1;
    endfunction

    logic [4:0]       wr_e, wr_m, wr_w;
    logic [2:0]       tnew_e, tnew_m, tnew_w;
    logic             start_e, div_e;
    logic [CNT_W-1:0] md_cnt;

    logic [4:0] rs, rt;
    logic [2:0] tuse_rs, tuse_rt;
    logic       haz_rs, haz_rt, md_busy, stall;

    assign rs      = Instr_D[25:21];
    assign rt      = Instr_D[20:16];
    assign tuse_rs = Tuse_D[5:3];
    assign tuse_rt = Tuse_D[2:0];

    // Tuse = 7 can never be exceeded by a 3-bit Tnew, so "not used" needs no special case.
    assign haz_rs = (rs != 5'd0) &&
                    (((rs == wr_e) && (tnew_e > tuse_rs)) ||
                     ((rs == wr_m) && (tnew_m > tuse_rs)));
    assign haz_rt = (rt != 5'd0) &&
                    (((rt == wr_e) && (tnew_e > tuse_rt)) ||
                     ((rt == wr_m) && (tnew_m > tuse_rt)));

    assign md_busy = (md_cnt != '0) | start_e;
    assign stall   = haz_rs | haz_rt | (MDUse_D & md_busy);

    assign Stall_O  = stall;
    assign ClrE_O   = stall;
    assign MDBusy_O = md_busy;

    // A younger producer in E shadows M, so forwarding from M is suppressed on an E match.
    assign ForwardRs_D_O = (rs != 5'd0) && (rs == wr_m) && (tnew_m == 3'd0) && (rs != wr_e);
    assign ForwardRt_D_O = (rt != 5'd0) && (rt == wr_m) && (tnew_m == 3'd0) && (rt != wr_e);

    // Scoreboard advance: E takes the D instruction or a bubble, M and W always shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_e    <= '0;
            tnew_e  <= '0;
            start_e <= 1'b0;
            div_e   <= 1'b0;
            wr_m    <= '0;
            tnew_m  <= '0;
            wr_w    <= '0;
            tnew_w  <= '0;
        end else begin
            if (stall) begin
                wr_e    <= '0;
                tnew_e  <= '0;
                start_e <= 1'b0;
                div_e   <= 1'b0;
            end else begin
                wr_e    <= RFWr_D ? WR_D : 5'd0;
                tnew_e  <= Tnew_D;
                start_e <= MDStart_D;
                div_e   <= MDStart_D & MDIsDiv_D;
            end
            wr_m   <= wr_e;
            tnew_m <= dec_sat0(tnew_e);
            wr_w   <= wr_m;
            tnew_w <= dec_sat0(tnew_m);
        end
    end

    // Mult/div busy countdown; a new start always wins over the decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (start_e) begin
            md_cnt <= div_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign StallCnt_O = stall_cnt;
`else
    assign StallCnt_O = 32'h0;
`endif

    // W is kept for pipeline bookkeeping only; write-through covers it.
    logic unused_bits;
    assign unused_bits = ^{Instr_D[31:26], Instr_D[15:0], wr_w, tnew_w};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: load-use, ALU-branch, $0, precedence, M-stage, mult/div and reset scenarios.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr_D;
    logic [5:0]  Tuse_D;
    logic [2:0]  Tnew_D;
    logic [4:0]  WR_D;
    logic        RFWr_D, MDStart_D, MDIsDiv_D, MDUse_D;
    logic        Stall_O, ClrE_O, ForwardRs_D_O, ForwardRt_D_O, MDBusy_O;
    logic [31:0] StallCnt_O;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Instr_D(Instr_D), .Tuse_D(Tuse_D), .Tnew_D(Tnew_D),
        .WR_D(WR_D), .RFWr_D(RFWr_D), .MDStart_D(MDStart_D), .MDIsDiv_D(MDIsDiv_D),
        .MDUse_D(MDUse_D), .Stall_O(Stall_O), .ClrE_O(ClrE_O), .ForwardRs_D_O(ForwardRs_D_O),
        .ForwardRt_D_O(ForwardRt_D_O), .MDBusy_O(MDBusy_O), .StallCnt_O(StallCnt_O)
    );

    always #5 clk = ~clk;

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] tuse,
                         input logic [2:0] tnew, input logic [4:0] wr, input logic rfwr,
                         input logic mdstart, input logic mddiv, input logic mduse);
        Instr_D   = {6'd0, rs, rt, 16'd0};
        Tuse_D    = tuse;
        Tnew_D    = tnew;
        WR_D      = wr;
        RFWr_D    = rfwr;
        MDStart_D = mdstart;
        MDIsDiv_D = mddiv;
        MDUse_D   = mduse;
        #1;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 6'o77, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) tick();
    endtask

    task automatic do_reset();
        nop();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        nop();
        reset = 1'b1;
        tick();
        checks++; if (Stall_O !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall_O); end
        checks++; if (ClrE_O !== 1'b0) begin errors++; $display("FAIL reset_clre: got %b want 0", ClrE_O); end
        checks++; if (ForwardRs_D_O !== 1'b0) begin errors++; $display("FAIL reset_fwdrs: got %b want 0", ForwardRs_D_O); end
        checks++; if (ForwardRt_D_O !== 1'b0) begin errors++; $display("FAIL reset_fwdrt: got %b want 0", ForwardRt_D_O); end
        checks++; if (MDBusy_O !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", MDBusy_O); end
        checks++; if (StallCnt_O !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", StallCnt_O); end
        reset = 1'b0;
        tick();
    endtask

    // lw $8 ; addu $9,$8,$8
    task automatic load_use_seq(input logic do_check);
        set_d(5'd29, 5'd0, 6'o17, 3'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        if (do_check) begin
            checks++; if (Stall_O !== 1'b0) begin errors++; $display("FAIL lu_issue_stall: got %b want 0", Stall_O); end
        end
        tick();
        set_d(5'd8, 5'd8, 6'o11, 3'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        if (do_check) begin
            checks++; if (Stall_O !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", Stall_O); end
            checks++; if (ClrE_O !== 1'b1) begin errors++; $display("FAIL lu_clre: got %b want 1", ClrE_O); end
        end
        tick();
        if (do_check) begin
            checks++; if (Stall_O !== 1'b0) begin errors++; $display("FAIL lu_after_bubble: got %b want 0", Stall_O); end
        end
        tick();
        flush();
    endtask

    task automatic test_load_use();
        load_use_seq(1'b1);
    endtask

    // addu $8 ; beq $8,$0
    task automatic test_alu_branch();
        set_d(5'd0, 5'd0, 6'o77, 3'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd8, 5'd0, 6'o00, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (Stall_O !== 1'b1) begin errors++; $display("FAIL br_stall: got %b want 1", Stall_O); end
        checks++; if (ForwardRs_D_O !== 1'b0) begin errors++; $display("FAIL br_fwd_early: got %b want 0", ForwardRs_D_O); end
        tick();
        checks++; if (Stall_O !== 1'b0) begin errors++; $display("FAIL br_release: got %b want 0", Stall_O); end
        checks++; if (ForwardRs_D_O !== 1'b1) begin errors++; $display("FAIL br_fwdrs: got %b want 1", ForwardRs_D_O); end
        checks++; if (ForwardRt_D_O !== 1'b0) begin errors++; $display("FAIL br_fwdrt_r0: got %b want 0", ForwardRt_D_O); end
        tick();
        flush();
    endtask

    // ori $0 ; addu $9,$0,$0
    task automatic test_zero_reg();
        set_d(5'd0, 5'd0, 6'o77, 3'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 6'o11, 3'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (Stall_O !== 1'b0) begin errors++; $display("FAIL zero_stall[%0d]: got %b want 0", i, Stall_O); end
            checks++; if ({ForwardRs_D_O, ForwardRt_D_O} !== 2'b00) begin errors++; $display("FAIL zero_fwd[%0d]: got %b want 00", i, {ForwardRs_D_O, ForwardRt_D_O}); end
            tick();
            nop();
            set_d(5'd0, 5'd0, 6'o00, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        flush();
    endtask

    // addu $8 ; beq $8,$8, then addu $8 ; addu $8 ; beq $8 (E shadows M)
    task automatic test_rs_eq_rt_precedence();
        set_d(5'd0, 5'd0, 6'o77, 3'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd8, 5'd8, 6'o00, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (Stall_O !== 1'b1) begin errors++; $display("FAIL eq_stall: got %b want 1", Stall_O); end
        tick();
        checks++; if ({ForwardRs_D_O, ForwardRt_D_O} !== 2'b11) begin errors++; $display("FAIL eq_fwd: got %b want 11", {ForwardRs_D_O, ForwardRt_D_O}); end
        tick();
        flush();
        set_d(5'd0, 5'd0, 6'o77, 3'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 6'o77, 3'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd8, 5'd0, 6'o00, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (Stall_O !== 1'b1) begin errors++; $display("FAIL prec_stall: got %b want 1", Stall_O); end
        checks++; if (ForwardRs_D_O !== 1'b0) begin errors++; $display("FAIL prec_fwd_suppressed: got %b want 0", ForwardRs_D_O); end
        tick();
        flush();
    endtask

    // Non-writing producer to $8 must not create a hazard or forward
    task automatic test_no_write();
        set_d(5'd0, 5'd0, 6'o77, 3'd2, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd8, 5'd0, 6'o00, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (Stall_O !== 1'b0) begin errors++; $display("FAIL nowr_stall: got %b want 0", Stall_O); end
        tick();
        checks++; if (ForwardRs_D_O !== 1'b0) begin errors++; $display("FAIL nowr_fwd: got %b want 0", ForwardRs_D_O); end
        flush();
    endtask

    // lw $8 ; nop ; beq $8 : hazard from M (Tnew 1), then W never stalls or forwards
    task automatic test_m_stage();
        set_d(5'd0, 5'd0, 6'o77, 3'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        set_d(5'd8, 5'd0, 6'o00, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (Stall_O !== 1'b1) begin errors++; $display("FAIL m_stall: got %b want 1", Stall_O); end
        checks++; if (ForwardRs_D_O !== 1'b0) begin errors++; $display("FAIL m_fwd_tnew1: got %b want 0", ForwardRs_D_O); end
        tick();
        checks++; if (Stall_O !== 1'b0) begin errors++; $display("FAIL w_stall: got %b want 0", Stall_O); end
        checks++; if (ForwardRs_D_O !== 1'b0) begin errors++; $display("FAIL w_fwd: got %b want 0", ForwardRs_D_O); end
        tick();
        flush();
    endtask

    // div ; mflo : busy 11 cycles after div enters E
    task automatic test_div();
        do_reset();
        set_d(5'd8, 5'd9, 6'o00, 3'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if ({Stall_O, MDBusy_O} !== 2'b00) begin errors++; $display("FAIL div_issue: got %b want 00", {Stall_O, MDBusy_O}); end
        tick();
        set_d(5'd0, 5'd0, 6'o77, 3'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            checks++; if ({Stall_O, MDBusy_O} !== 2'b11) begin errors++; $display("FAIL div_busy[%0d]: got %b want 11", i, {Stall_O, MDBusy_O}); end
            tick();
        end
        checks++; if ({Stall_O, MDBusy_O} !== 2'b00) begin errors++; $display("FAIL div_done: got %b want 00", {Stall_O, MDBusy_O}); end
        tick();
        flush();
    endtask

    // mult ; mfhi with reset pulsed mid-countdown
    task automatic test_mult_reset();
        do_reset();
        set_d(5'd8, 5'd9, 6'o00, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        set_d(5'd0, 5'd0, 6'o77, 3'd1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (Stall_O !== 1'b1) begin errors++; $display("FAIL mult_stall: got %b want 1", Stall_O); end
        tick();
        tick();
        checks++; if (MDBusy_O !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b want 1", MDBusy_O); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (MDBusy_O !== 1'b0) begin errors++; $display("FAIL mult_rst_busy: got %b want 0", MDBusy_O); end
        checks++; if ({Stall_O, ClrE_O, ForwardRs_D_O, ForwardRt_D_O} !== 4'b0000) begin errors++; $display("FAIL mult_rst_outs: got %b want 0000", {Stall_O, ClrE_O, ForwardRs_D_O, ForwardRt_D_O}); end
        #2;
        reset = 1'b0;
        tick();
        checks++; if ({Stall_O, MDBusy_O} !== 2'b00) begin errors++; $display("FAIL mult_after_rst: got %b want 00", {Stall_O, MDBusy_O}); end
        flush();
    endtask

    task automatic test_perf_cnt();
        logic [31:0] expect_cnt;
`ifdef HAZ_PERF_CNT_EN
        expect_cnt = 32'd3;
`else
        expect_cnt = 32'd0;
`endif
        do_reset();
        for (int i = 0; i < 3; i++) load_use_seq(1'b0);
        checks++; if (StallCnt_O !== expect_cnt) begin errors++; $display("FAIL perf_cnt: got %0d want %0d", StallCnt_O, expect_cnt); end
    endtask

    initial begin
        nop();
        test_reset();
        test_load_use();
        test_alu_branch();
        test_zero_reg();
        test_rs_eq_rt_precedence();
        test_no_write();
        test_m_stage();
        test_div();
        test_mult_reset();
        test_perf_cnt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
